// File: rtl/sdram_arb_pkg.sv
// Shared types and default timing constants for the SDRAM port arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ST_ACC,
    AUX_ACC,
    REF
  } arb_state_t;

  localparam int unsigned ACC_CYCLES_DEF = 4;
  localparam int unsigned AUX_GAP_DEF    = 2;

endpackage

// File: rtl/sdram_arb_port_latch.sv
// One-deep holding slot for an ST access and an ST refresh that arrive while the SDRAM is busy.
module sdram_arb_port_latch (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs_cap,
  input  logic        cs_clr,
  input  logic        ref_cap,
  input  logic        ref_clr,
  input  logic        we_in,
  input  logic [21:0] addr_in,
  input  logic [15:0] din_in,
  input  logic [1:0]  ds_in,
  output logic        cs_vld,
  output logic        ref_vld,
  output logic        we,
  output logic [21:0] addr,
  output logic [15:0] din,
  output logic [1:0]  ds,
  output logic        overrun
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_vld  <= 1'b0;
      ref_vld <= 1'b0;
      we      <= 1'b0;
      addr    <= '0;
      din     <= '0;
      ds      <= '1;
      overrun <= 1'b0;
    end else begin
      // A slot being drained this cycle can accept the new request in the same edge.
      if (cs_cap && (!cs_vld || cs_clr)) begin
        cs_vld <= 1'b1;
        we     <= we_in;
        addr   <= addr_in;
        din    <= din_in;
        ds     <= ds_in;
      end else if (cs_cap) begin
        overrun <= 1'b1;
      end else if (cs_clr) begin
        cs_vld <= 1'b0;
      end

      if (ref_cap)
        ref_vld <= 1'b1;
      else if (ref_clr)
        ref_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/sdram_arb.sv
// Arbitrates the ST chipset port and an aux (MCU/DMA) port onto one SDRAM controller.
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ACC_CYCLES = ACC_CYCLES_DEF,
  parameter int unsigned AUX_GAP    = AUX_GAP_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ram_ready,
  input  logic        st_cs,
  input  logic        st_we,
  input  logic        st_refresh,
  input  logic [21:0] st_addr,
  input  logic [15:0] st_din,
  input  logic [1:0]  st_ds,
  output logic [15:0] st_dout,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [21:0] aux_addr,
  input  logic [15:0] aux_din,
  input  logic [1:0]  aux_ds,
  output logic        aux_ack,
  output logic [15:0] aux_dout,
  output logic        sd_cs,
  output logic        sd_we,
  output logic        sd_refresh,
  output logic [21:0] sd_addr,
  output logic [15:0] sd_din,
  output logic [1:0]  sd_ds,
  input  logic [15:0] sd_dout
);

  localparam int unsigned CW = $clog2(ACC_CYCLES + 1);
  localparam int unsigned IW = $clog2(AUX_GAP + 1);
  localparam logic [CW-1:0] LAST = CW'(ACC_CYCLES - 1);
  localparam logic [IW-1:0] GAP  = IW'(AUX_GAP);

  arb_state_t    state, state_nx;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idle_cnt;

  logic          lat_cs, lat_ref, lat_we, st_overrun;
  logic [21:0]   lat_addr;
  logic [15:0]   lat_din;
  logic [1:0]    lat_ds;

  logic          last, grant_ok, ref_pend, st_pend;
  logic          go_ref, go_st, go_aux;
  logic          cs_cap, cs_clr, ref_cap, ref_clr;

  assign last     = (state != IDLE) && (cnt == LAST);
  assign ref_pend = st_refresh | lat_ref;
  assign st_pend  = st_cs | lat_cs;

  // The older latched ST request is served before a live one; the live one then takes the slot.
  assign cs_cap  = st_cs && !(go_st && !lat_cs);
  assign cs_clr  = go_st && lat_cs;
  assign ref_cap = st_refresh && !(go_ref && !lat_ref);
  assign ref_clr = go_ref && lat_ref;

  sdram_arb_port_latch u_port_latch (
    .clk     (clk),
    .reset_n (reset_n),
    .cs_cap  (cs_cap),
    .cs_clr  (cs_clr),
    .ref_cap (ref_cap),
    .ref_clr (ref_clr),
    .we_in   (st_we),
    .addr_in (st_addr),
    .din_in  (st_din),
    .ds_in   (st_ds),
    .cs_vld  (lat_cs),
    .ref_vld (lat_ref),
    .we      (lat_we),
    .addr    (lat_addr),
    .din     (lat_din),
    .ds      (lat_ds),
    .overrun (st_overrun)
  );

  // ST work chains straight off the final busy cycle; aux is only granted from IDLE,
  // and never in the ack cycle, where the finished request is still held high.
  always_comb begin
    state_nx = state;
    grant_ok = ram_ready && ((state == IDLE) || last);
    go_ref   = 1'b0;
    go_st    = 1'b0;
    go_aux   = 1'b0;
    if (grant_ok && ref_pend)
      go_ref = 1'b1;
    else if (grant_ok && st_pend)
      go_st = 1'b1;
    else if (ram_ready && (state == IDLE) && aux_req && !aux_ack && (idle_cnt >= GAP))
      go_aux = 1'b1;

    if (go_ref)
      state_nx = REF;
    else if (go_st)
      state_nx = ST_ACC;
    else if (go_aux)
      state_nx = AUX_ACC;
    else if (last)
      state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (go_ref || go_st || go_aux)
        cnt <= '0;
      else if (state != IDLE)
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      idle_cnt <= '0;
    else if (st_cs || st_refresh)
      idle_cnt <= '0;
    else if (idle_cnt < GAP)
      idle_cnt <= idle_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sd_cs      <= 1'b0;
      sd_we      <= 1'b0;
      sd_refresh <= 1'b0;
      sd_addr    <= '0;
      sd_din     <= '0;
      sd_ds      <= '1;
      st_dout    <= '0;
      aux_ack    <= 1'b0;
      aux_dout   <= '0;
    end else begin
      sd_cs      <= go_st | go_aux;
      sd_refresh <= go_ref;
      aux_ack    <= 1'b0;
      if (go_st) begin
        sd_we   <= lat_cs ? lat_we   : st_we;
        sd_addr <= lat_cs ? lat_addr : st_addr;
        sd_din  <= lat_cs ? lat_din  : st_din;
        sd_ds   <= lat_cs ? lat_ds   : st_ds;
      end else if (go_aux) begin
        sd_we   <= aux_we;
        sd_addr <= aux_addr;
        sd_din  <= aux_din;
        sd_ds   <= aux_ds;
      end
      if (last && (state == ST_ACC) && !sd_we)
        st_dout <= sd_dout;
      if (last && (state == AUX_ACC)) begin
        aux_ack <= 1'b1;
        if (!sd_we)
          aux_dout <= sd_dout;
      end
    end
  end

  a_no_st_overrun: assert property (@(posedge clk) disable iff (!reset_n) !st_overrun);
  a_cs_ref_excl:   assert property (@(posedge clk) disable iff (!reset_n) !(sd_cs && sd_refresh));

endmodule

// File: doc/sdram_arb.md
SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 Parameter ACC_CYCLES, default 4, clk cycles from downstream cs pulse to downstream dout valid.
REQ-002 Parameter AUX_GAP, default 2, minimum idle clk cycles on the ST port before an aux access may start.
REQ-003 clk  in  1  32 MHz system clock; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ram_ready  in  1  SDRAM initialisation complete.
REQ-006 st_cs, st_we, st_refresh  in  1 each  ST chipset access strobe, write enable, refresh request.
REQ-007 st_addr  in  22  ST word address; st_din  in  16; st_ds  in  2  active-low byte strobes.
REQ-008 st_dout  out  16  read data for ST.
REQ-009 aux_req, aux_we  in  1 each  aux (MCU/DMA) request and write enable.
REQ-010 aux_addr  in  22; aux_din  in  16; aux_ds  in  2  active-low.
REQ-011 aux_ack  out  1  one-cycle pulse, aux access complete; aux_dout  out  16  valid with aux_ack.
REQ-012 sd_cs, sd_we, sd_refresh  out  1 each; sd_addr  out  22; sd_din  out  16; sd_ds  out  2  to sdram controller.
REQ-013 sd_dout  in  16  read data from sdram controller.

Function
REQ-014 States: IDLE, ST_ACC, AUX_ACC, REF; transitions evaluated every clk.
REQ-015 IDLE priority: st_refresh, then st_cs (or latched ST request), then aux_req; nothing is granted while ram_ready=0.
REQ-016 ST grant: sd_cs pulses one cycle, driving sd_* from the ST port, registered; then ST_ACC for ACC_CYCLES cycles.
REQ-017 st_dout loads sd_dout on the final ST_ACC cycle and holds until the next ST read completes.
REQ-018 Aux grant requires aux_req=1, st_cs=0, st_refresh=0 and an ST idle counter >= AUX_GAP.
REQ-019 Aux access: sd_* from the aux port, latched at grant; AUX_ACC lasts ACC_CYCLES.
REQ-020 aux_ack pulses on the final AUX_ACC cycle; aux_dout takes sd_dout on reads and is unchanged on writes.
REQ-021 The requester holds aux_req and aux_* stable until aux_ack; a request still high the cycle after ack is a new request.
REQ-022 st_cs or st_refresh rising during AUX_ACC or ST_ACC is latched (one-deep per type), and aux_* are never re-sampled.
REQ-023 After AUX_ACC/ST_ACC ends, a latched refresh is issued first, then a latched ST access; worst-case ST delay is 2*ACC_CYCLES+1 cycles.
REQ-024 A second ST request while one is already latched is an overrun: it is dropped and a sticky internal flag is set for simulation assertion.
REQ-025 REF: sd_refresh pulses one cycle, then the FSM waits ACC_CYCLES cycles and returns to IDLE.
REQ-026 Simultaneous st_cs and aux_req in IDLE: ST wins; aux stays pending.
REQ-027 ST idle counter saturates at AUX_GAP, clears on st_cs or st_refresh, and its width is clog2(AUX_GAP+1).
REQ-028 sd_cs and sd_refresh are never both high in the same cycle.
REQ-029 ram_ready falling mid-access: the current access completes, then the FSM stays in IDLE.

Reset
REQ-030 reset_n low: state=IDLE; sd_cs, sd_we, sd_refresh, aux_ack=0; sd_addr, sd_din, st_dout, aux_dout=0; sd_ds=2'b11; latches, counters and overrun flag cleared.
REQ-031 reset_n asserting mid-access aborts immediately, and the aborted aux access is not acknowledged.

Structure
REQ-032 Shared package sdram_arb_pkg holds the state enum and default parameter constants.
REQ-033 A single sub-module, sdram_arb_port_latch, implements the one-deep ST request latch (cs, we, refresh, addr, din, ds).

Verification
REQ-034 ST read at 0x000100 with ram_ready=1 -> sd_cs at +1 cycle; st_dout=model data after ACC_CYCLES; aux_ack stays 0.
REQ-035 aux_req write 0x3FFFFF/0xBEEF with ST idle for 2 cycles -> sd_we=1 with sd_din=0xBEEF; aux_ack once, 4 cycles after sd_cs.
REQ-036 st_cs and aux_req in the same cycle -> ST served first; aux acked after ST completes plus AUX_GAP idle.
REQ-037 st_cs 1 cycle into AUX_ACC -> aux completes; ST sd_cs issued the next cycle; ST data correct; overrun flag 0.
REQ-038 st_refresh and latched st_cs pending at the end of AUX_ACC -> sd_refresh first, then sd_cs after ACC_CYCLES.
REQ-039 reset_n pulsed low during AUX_ACC -> outputs match reset values immediately; no aux_ack; next aux_req serviced normally.
